spi_bus_arbiter: RTL
====================

# spi_bus_arbiter

Two-requester arbiter that shares one `simple_spi_master` instance between the e-ink display command/pixel sequencer (requester 0) and the frame-buffer SRAM client (requester 1). It grants the bus for whole transactions, steers the master's write/read/stream controls and per-requester prescaler, routes the master's single CSB to the proper device select, and enforces a CSB-high guard gap between transactions. It sits between the display/SRAM sequencers and the SPI master in the top-level design.

## Interface
- `PRESC0`, 8'd2, prescaler driven to the master while requester 0 (display, 20 MHz max) owns the bus
- `PRESC1`, 8'd4, prescaler while requester 1 (SRAM, 2.5 MHz max) owns the bus
- `GUARD`, 4, idle cycles with both selects high between transactions (1..15)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  bus request; held high for the whole transaction
- `we0`, `we1`  in  1  byte write strobe (master `reg_dat_we` semantics)
- `re0`, `re1`  in  1  byte read strobe
- `di0`, `di1`  in  8  byte to transmit
- `strm0`, `strm1`  in  1  stream (keep CSB low between bytes)
- `gnt0`, `gnt1`  out  1  bus granted (registered, one-hot or zero)
- `wait0`, `wait1`  out  1  per-requester wait status
- `dout`  out  8  master read data, broadcast to both requesters
- `err`  out  1  sticky protocol-error flag
- `m_we`, `m_re`  out  1  to master `reg_dat_we` / `reg_dat_re`
- `m_di`  out  8  to master `reg_dat_di`
- `m_stream`  out  1  to master `stream`
- `m_presc`  out  8  to master `prescaler`
- `m_wait`  in  1  from master `reg_dat_wait`
- `m_do`  in  8  from master `reg_dat_do`
- `m_csb`  in  1  from master `csb`
- `csb_disp`, `csb_sram`  out  1  device selects (active low)

## Operation
- States: IDLE, ACTIVE, GUARD. Reset: IDLE, `gnt0`=`gnt1`=0, `err`=0, `m_presc`=PRESC0, last-served pointer `last`=1 (requester 0 wins the first tie), guard counter 0.
- IDLE: if exactly one `reqN` high, grant N. If both high, grant the requester not equal to `last`. Set `gntN`, `last`<=N, `m_presc`<=PRESCN, go ACTIVE. No request: stay.
- ACTIVE (owner N): `m_we`=`weN`, `m_re`=`reN`, `m_di`=`diN`, `m_stream`=`strmN` (combinational steering gated by `gntN`); `csb_disp`=`m_csb` if N=0 else 1; `csb_sram`=`m_csb` if N=1 else 1. `waitN`=`m_wait`.
- ACTIVE exit: `reqN`=0 and `m_wait`=0 in the same cycle -> clear `gntN`, load guard counter with GUARD-1, go GUARD. `reqN` dropping while `m_wait`=1 is held off until the byte completes.
- GUARD: `m_stream`=0, `m_we`=`m_re`=0, both selects 1; decrement; at 0 go IDLE. Requests seen here are served in the following IDLE cycle.
- Outside ACTIVE, and for the non-owner always: `m_we`=`m_re`=`m_stream`=0, `m_di`=0, `waitN`=1, selects high.
- `err` set (sticky until `rst`) when a requester pulses `we`/`re` without its grant, or when the owner pulses `we`/`re` while `m_wait`=1.
- `dout`=`m_do` always. `m_presc` changes only on the IDLE->ACTIVE edge, stable throughout ACTIVE and GUARD.

## Timing
- Grant latency: `req` high sampled in IDLE at edge k -> `gnt` high after edge k; earliest useful `we` is the following cycle. Minimum gap between transactions from one requester: 1 (release) + GUARD + 1 (IDLE) cycles.
- Requesters must wait for `gnt`, then for `wait`=0, before each strobe; strobe is one cycle wide.
- Async `rst` mid-transaction: all outputs return to reset values immediately; selects go high, `m_stream`=0; the master is reset by the same domain and any partial byte is discarded.
- A request that is dropped before grant is never granted; no request is queued.

## Test plan
- Reset then `req0` only: `gnt0`=1 one cycle later, `m_presc`=2; write 0x12 via `we0` -> `m_di`=0x12, `csb_disp` follows `m_csb`, `csb_sram` stays 1.
- `req0` and `req1` rise together from reset: `gnt0` first; after release and 4 guard cycles `gnt1`=1, `m_presc`=4; next simultaneous tie goes to 0 (round robin).
- `req1` owns bus streaming 3 bytes with `strm1`=1; `req0` asserted midway: `wait0`=1, `gnt0`=0 until `req1` drops and guard elapses; `m_stream` never glitches low between the 3 bytes.
- `we1` pulsed while only `gnt0`=1: `m_we` stays 0, `err`=1 and remains 1 until `rst`.
- Owner drops `req0` while `m_wait`=1: grant held until `m_wait`=0, then GUARD of exactly GUARD cycles with both selects 1.
- Assert `rst` during an ACTIVE byte: `gnt0`, `m_stream`, `m_we` go 0 and selects 1 without waiting for a clock edge; after release, arbitration restarts with requester 0 priority.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Purpose : shares one simple_spi_master between the display sequencer (req 0)
//           and the frame-buffer SRAM client (req 1), whole transactions at a time.
// Latency : req sampled in IDLE -> gnt registered after that edge; steering is combinational.
// Backpressure: non-owner sees wait=1; owner sees master reg_dat_wait; a CSB-high
//           guard gap of GUARD cycles separates consecutive transactions.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0/1                    bus request, held for the whole transaction
//   we0/1, re0/1, di0/1       per-requester byte write/read strobes and write data
//   strm0/1                   per-requester stream (keep CSB low between bytes)
//   gnt0/1                    registered grant, one-hot or zero
//   wait0/1                   per-requester wait status (1 unless owner and master idle)
//   dout                      master read data, broadcast
//   err                       sticky protocol-error flag
//   m_we, m_re, m_di          steered strobes/data to the master
//   m_stream, m_presc         steered stream flag and owner prescaler
//   m_wait, m_do, m_csb       master status, read data and chip select
//   csb_disp, csb_sram        active-low device selects
module spi_bus_arbiter #(
    parameter logic [7:0]  PRESC0 = 8'd2,
    parameter logic [7:0]  PRESC1 = 8'd4,
    parameter int unsigned GUARD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic       re0,
    input  logic       re1,
    input  logic [7:0] di0,
    input  logic [7:0] di1,
    input  logic       strm0,
    input  logic       strm1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       wait0,
    output logic       wait1,
    output logic [7:0] dout,
    output logic       err,
    output logic       m_we,
    output logic       m_re,
    output logic [7:0] m_di,
    output logic       m_stream,
    output logic [7:0] m_presc,
    input  logic       m_wait,
    input  logic [7:0] m_do,
    input  logic       m_csb,
    output logic       csb_disp,
    output logic       csb_sram
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    // Counter runs GUARD-1 .. 0, giving exactly GUARD cycles in ST_GUARD.
    localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

    state_t     state_q;
    state_t     state_d;
    logic       gnt0_d;
    logic       gnt1_d;
    logic       last_q;
    logic       last_d;
    logic [7:0] presc_d;
    logic [3:0] gcnt_q;
    logic [3:0] gcnt_d;

    logic       own0;
    logic       own1;
    logic       owner_req;
    logic       strobe0;
    logic       strobe1;
    logic       violation;

    // Ownership is only meaningful while ACTIVE; gating on state as well as the
    // grant keeps the steering dead in IDLE/GUARD even if a grant were stale.
    assign own0      = gnt0 && (state_q == ST_ACTIVE);
    assign own1      = gnt1 && (state_q == ST_ACTIVE);
    assign owner_req = gnt0 ? req0 : req1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            last_q  <= 1'b1;
            m_presc <= PRESC0;
            gcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt0    <= gnt0_d;
            gnt1    <= gnt1_d;
            last_q  <= last_d;
            m_presc <= presc_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0;
        gnt1_d  = gnt1;
        last_d  = last_q;
        presc_d = m_presc;
        gcnt_d  = gcnt_q;

        case (state_q)
            ST_IDLE: begin
                // Requester 0 wins alone, or on a tie when 1 was served last.
                if (req0 && (!req1 || last_q)) begin
                    gnt0_d  = 1'b1;
                    last_d  = 1'b0;
                    presc_d = PRESC0;
                    state_d = ST_ACTIVE;
                end else if (req1) begin
                    gnt1_d  = 1'b1;
                    last_d  = 1'b1;
                    presc_d = PRESC1;
                    state_d = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                // A release is held off until any byte in flight has finished.
                if (!owner_req && !m_wait) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    gcnt_d  = GUARD_LOAD;
                    state_d = ST_GUARD;
                end
            end

            ST_GUARD: begin
                if (gcnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Master steering and device selects
    // ------------------------------------------------------------------
    always_comb begin
        m_we     = (own0 & we0)   | (own1 & we1);
        m_re     = (own0 & re0)   | (own1 & re1);
        m_stream = (own0 & strm0) | (own1 & strm1);
        m_di     = 8'h00;
        if (own0) begin
            m_di = di0;
        end else if (own1) begin
            m_di = di1;
        end
    end

    assign wait0    = own0 ? m_wait : 1'b1;
    assign wait1    = own1 ? m_wait : 1'b1;
    assign csb_disp = own0 ? m_csb  : 1'b1;
    assign csb_sram = own1 ? m_csb  : 1'b1;
    assign dout     = m_do;

    // ------------------------------------------------------------------
    // Sticky protocol error: strobe without ownership, or owner strobing
    // while the master is still busy with the previous byte.
    // ------------------------------------------------------------------
    assign strobe0   = we0 | re0;
    assign strobe1   = we1 | re1;
    assign violation = (strobe0 && (!own0 || m_wait)) ||
                       (strobe1 && (!own1 || m_wait));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end

    // Grants are never both high; the prescaler only moves on IDLE->ACTIVE.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_presc_stable : assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_IDLE) |=> $stable(m_presc));

endmodule
